// File: rtl/rsp_receiver.sv
// SD card CMD-line response receiver: waits for the start bit, shifts in a 48- or 136-bit
// frame, checks CRC7, index and end bit, and reports the result with a one-cycle done pulse.
module rsp_receiver #(
    parameter int TimeoutCycles = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sd_clk_en_i,
    input  logic         sd_cmd_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic         long_rsp_i,
    input  logic         index_check_en_i,
    input  logic         crc_check_en_i,
    input  logic [5:0]   expected_index_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [119:0] rsp_o,
    output logic [5:0]   rsp_index_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         end_bit_err_o,
    output logic         index_err_o
);

    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

    state_t          state;
    logic [TW-1:0]   timeout_cnt;
    logic [7:0]      bit_cnt;
    logic [132:0]    shreg;
    logic [6:0]      crc;
    logic            long_q;
    logic            index_en_q;
    logic            crc_en_q;
    logic [5:0]      exp_index_q;

    // Frame as it stands once the bit currently on the line is included; bit 0 is the end bit.
    logic [133:0]    frame;
    logic            crc_fb;
    logic [6:0]      crc_next;
    logic            crc_in_range;
    logic [5:0]      idx_field;
    logic [119:0]    rsp_field;

    assign frame        = {shreg, sd_cmd_i};
    assign crc_fb       = crc[6] ^ sd_cmd_i;
    assign crc_next     = {crc[5:3], crc[2] ^ crc_fb, crc[1:0], crc_fb};
    // The start bit is never fed in: it is always 0, which leaves a zero CRC unchanged.
    assign crc_in_range = (bit_cnt >= 8'd8) && (bit_cnt <= 8'd127);
    assign idx_field    = long_q ? frame[133:128] : frame[45:40];
    assign rsp_field    = long_q ? frame[127:8] : {88'b0, frame[39:8]};

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values and evaluation order inside the block does not matter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the shift register is plain flops, not a RAM, so it is reset along with
            // the rest; a frame cut by reset can never leak into the next response.
            state         <= IDLE;
            timeout_cnt   <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            crc           <= '0;
            long_q        <= 1'b0;
            index_en_q    <= 1'b0;
            crc_en_q      <= 1'b0;
            exp_index_q   <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            rsp_o         <= '0;
            rsp_index_o   <= '0;
            timeout_err_o <= 1'b0;
            crc_err_o     <= 1'b0;
            end_bit_err_o <= 1'b0;
            index_err_o   <= 1'b0;
        end else if (abort_i) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            timeout_err_o <= 1'b0;
            crc_err_o     <= 1'b0;
            end_bit_err_o <= 1'b0;
            index_err_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        long_q        <= long_rsp_i;
                        index_en_q    <= index_check_en_i;
                        crc_en_q      <= crc_check_en_i;
                        exp_index_q   <= expected_index_i;
                        timeout_cnt   <= '0;
                        bit_cnt       <= '0;
                        shreg         <= '0;
                        crc           <= '0;
                        rsp_o         <= '0;
                        rsp_index_o   <= '0;
                        timeout_err_o <= 1'b0;
                        crc_err_o     <= 1'b0;
                        end_bit_err_o <= 1'b0;
                        index_err_o   <= 1'b0;
                        busy_o        <= 1'b1;
                        state         <= WAIT_START;
                    end
                end

                WAIT_START: begin
                    if (sd_clk_en_i) begin
                        if (!sd_cmd_i) begin
                            bit_cnt <= long_q ? 8'd134 : 8'd46;
                            state   <= RECEIVE;
                        end else if (timeout_cnt == TimeoutLast) begin
                            timeout_err_o <= 1'b1;
                            busy_o        <= 1'b0;
                            done_o        <= 1'b1;
                            state         <= DONE;
                        end else begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                        end
                    end
                end

                RECEIVE: begin
                    if (sd_clk_en_i) begin
                        shreg <= frame[132:0];
                        if (crc_in_range) begin
                            crc <= crc_next;
                        end
                        if (bit_cnt == 8'd0) begin
                            rsp_o         <= rsp_field;
                            rsp_index_o   <= idx_field;
                            crc_err_o     <= crc_en_q && (crc != frame[7:1]);
                            index_err_o   <= index_en_q && !long_q && (idx_field != exp_index_q);
                            end_bit_err_o <= !sd_cmd_i;
                            busy_o        <= 1'b0;
                            done_o        <= 1'b1;
                            state         <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rsp_receiver.md
RSP_RECEIVER -- requirements
Module: rsp_receiver

Interface
- REQ-001 SHALL have parameter TimeoutCycles, default 64: the number of sd_clk_en_i pulses allowed between arm and start bit (Ncr limit).
- REQ-002 SHALL have port clk_i, input, 1: the system clock.
- REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
- REQ-004 SHALL have port sd_clk_en_i, input, 1: one-cycle pulse marking the SD clock rising-edge sample point.
- REQ-005 SHALL have port sd_cmd_i, input, 1: the CMD line, already synchronized.
- REQ-006 SHALL have port start_i, input, 1: arms reception after the host command end bit.
- REQ-007 SHALL have port abort_i, input, 1: synchronous abort.
- REQ-008 SHALL have port long_rsp_i, input, 1: 1 selects a 136-bit (R2) frame, 0 selects a 48-bit frame; sampled on start_i.
- REQ-009 SHALL have ports index_check_en_i and crc_check_en_i, input, 1 each; sampled on start_i.
- REQ-010 SHALL have port expected_index_i, input, 6: the command index to match; sampled on start_i.
- REQ-011 SHALL have port busy_o, output, 1: high while armed or receiving.
- REQ-012 SHALL have port done_o, output, 1: one-cycle completion pulse.
- REQ-013 SHALL have port rsp_o, output, 120: response payload.
- REQ-014 SHALL have port rsp_index_o, output, 6: received index field.
- REQ-015 SHALL have ports timeout_err_o, crc_err_o, end_bit_err_o and index_err_o, output, 1 each; valid when done_o is high and held until the next start_i.

Function
- REQ-016 SHALL implement FSM states IDLE, WAIT_START, RECEIVE and DONE; all outputs are registered.
- REQ-017 IDLE: on start_i, SHALL latch the config inputs, clear rsp_o and all error flags, and go to WAIT_START; busy_o is high from the next cycle.
- REQ-018 WAIT_START: on each sd_clk_en_i, sd_cmd_i=0 SHALL be taken as the start bit and the FSM goes to RECEIVE; otherwise the timeout counter increments.
- REQ-019 WAIT_START: when the timeout counter reaches TimeoutCycles, the FSM SHALL go to DONE with timeout_err_o=1 and all other errors 0.
- REQ-020 A start bit sampled on the same pulse that would reach TimeoutCycles SHALL win over the timeout.
- REQ-021 RECEIVE SHALL shift in one bit per sd_clk_en_i, MSB first, counting 47 (short) or 135 (long) bits after the start bit; the bit counter is 8 bits wide.
- REQ-022 Frame bit n SHALL mean frame position n, with 47 (short) or 135 (long) being the start bit and 0 the end bit.
- REQ-023 Short frame: rsp_index_o SHALL be frame[45:40] and rsp_o[31:0] SHALL be frame[39:8], with rsp_o[119:32] zero.
- REQ-024 Long frame: rsp_o SHALL be frame[127:8] and rsp_index_o SHALL be frame[133:128].
- REQ-025 CRC7 SHALL be computed serially with polynomial x^7+x^3+1 and initial value 0.
- REQ-026 The CRC SHALL cover frame[47:8] for a short frame and frame[127:8] for a long frame, and SHALL be compared to frame[7:1].
- REQ-027 crc_err_o SHALL be (mismatch AND crc_check_en).
- REQ-028 index_err_o SHALL be (rsp_index_o != expected_index AND index_check_en AND short frame); a long frame never sets index_err_o.
- REQ-029 end_bit_err_o SHALL be 1 when frame bit 0 is 0.
- REQ-030 The transmission bit SHALL be captured but not checked.
- REQ-031 The final sd_clk_en_i (end bit) SHALL lead to DONE; done_o is high in the cycle after that pulse, with errors and rsp_o valid in the same cycle.
- REQ-032 DONE SHALL return to IDLE after one cycle; busy_o is low in DONE.
- REQ-033 start_i while busy_o or in DONE SHALL be ignored.
- REQ-034 abort_i in any state SHALL force IDLE on the next edge with no done_o pulse and error flags cleared; abort_i wins over a simultaneous start_i or completion.
- REQ-035 Without sd_clk_en_i pulses the FSM, counters and shift register SHALL hold.

Reset
- REQ-036 rst_i SHALL asynchronously force IDLE and zero all counters, the shift register, the CRC and every output (busy_o=0, done_o=0, rsp_o=0, rsp_index_o=0, all errors 0).
- REQ-037 Reset mid-reception SHALL discard the frame, and the first start_i after release SHALL behave as from cold.

Verification
- REQ-038 Short frame with index 12, argument 0x0000007A, valid CRC, 2 idle SD clocks before the start bit, expected index 12, both checks enabled -> done_o, rsp_o=0x7A, rsp_index_o=12, no errors.
- REQ-039 Same frame with expected_index_i=0 -> index_err_o=1 only; with index 0x3F, argument 0xFFFFFFFF and a wrong CRC -> crc_err_o=1 and index_err_o=1; both checks disabled -> no errors.
- REQ-040 CMD held high -> timeout_err_o on the 64th sd_clk_en_i pulse; start bit on pulse 63 -> normal reception, no timeout.
- REQ-041 Long R2 frame with known CID and valid CRC -> rsp_o=frame[127:8], index_err_o=0 even with index check enabled and expected index 2.
- REQ-042 End bit driven 0 -> end_bit_err_o=1.
- REQ-043 abort_i at bit 20 -> busy_o=0 next cycle and no done_o pulse.
- REQ-044 rst_i mid-frame -> all outputs 0 immediately.
- REQ-045 Every scenario SHALL be run with sd_clk_en_i periods of 1, 2 and 4 clk_i cycles.
